// File: rtl/floyd_warshall_pkg.sv
// Shared constants, FSM state type and address helper for the Floyd-Warshall kernel.
package floyd_warshall_pkg;

  localparam int unsigned N  = 8;   // matrix dimension
  localparam int unsigned AW = 6;   // log2(N*N)
  localparam int unsigned DW = 32;  // signed distance width

  typedef enum logic [2:0] {
    StIdle,
    StRIk,
    StRKj,
    StRIj,
    StCmp,
    StWr
  } state_e;

  // Row-major word address: row*8 + col.
  function automatic logic [AW-1:0] idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/floyd_warshall_kernel_relax.sv
// Combinational signed min-plus unit: r = min(a_ij, a_ik + a_kj).
// The sum wraps in 32-bit two's complement; the compare is signed and strict,
// so a tie selects the sum (same value either way).
// Ports:
//   a_ik_i, a_kj_i, a_ij_i : operand distances
//   r_o                    : relaxed distance
module fw_relax
  import floyd_warshall_pkg::*;
(
  input  logic [DW-1:0] a_ik_i,
  input  logic [DW-1:0] a_kj_i,
  input  logic [DW-1:0] a_ij_i,
  output logic [DW-1:0] r_o
);

  logic [DW-1:0] sum;

  always_comb begin
    sum = a_ik_i + a_kj_i;
    r_o = ($signed(a_ij_i) < $signed(sum)) ? a_ij_i : sum;
  end

endmodule

// File: rtl/floyd_warshall_kernel.sv
// In-place Floyd-Warshall over a fixed 8x8 signed distance matrix held in an
// external memory with a registered read port and a synchronous write port.
// Each (k,i,j) triple takes five cycles: three reads, a compare cycle, a write.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   t                     : start pulse, honoured only while idle
//   n                     : problem size, unused (dimension fixed at 8)
//   path_r_p0_*           : read port (addr, addr valid, read enable, read data)
//   path_w_p0_*           : write port (addr, addr valid, write enable, write data)
//   done                  : one-cycle pulse after the final write
module floyd_warshall_kernel
  import floyd_warshall_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          t,
  input  logic [31:0]   n,
  output logic [AW-1:0] path_r_p0_addr_data,
  output logic          path_r_p0_addr_en,
  output logic          path_r_p0_rd_en,
  input  logic [DW-1:0] path_r_p0_rd_data,
  output logic [AW-1:0] path_w_p0_addr_data,
  output logic          path_w_p0_addr_en,
  output logic          path_w_p0_wr_en,
  output logic [DW-1:0] path_w_p0_wr_data,
  output logic          done
);

  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d, i_q, i_d, j_q, j_d;
  logic [DW-1:0] a_ik_q, a_ik_d, a_kj_q, a_kj_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d, done_q, done_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [DW-1:0] relax_r;
  logic          n_unused;

  assign n_unused = ^n;

  // In the compare cycle the read data is a_ij, so it feeds the unit directly.
  fw_relax u_relax (
    .a_ik_i (a_ik_q),
    .a_kj_i (a_kj_q),
    .a_ij_i (path_r_p0_rd_data),
    .r_o    (relax_r)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    a_ik_d    = a_ik_q;
    a_kj_d    = a_kj_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (t) begin
          state_d   = StRIk;
          rd_en_d   = 1'b1;
          rd_addr_d = idx(i_q, k_q);
        end
      end
      StRIk: begin
        state_d   = StRKj;
        rd_en_d   = 1'b1;
        rd_addr_d = idx(k_q, j_q);
      end
      StRKj: begin
        a_ik_d    = path_r_p0_rd_data;
        state_d   = StRIj;
        rd_en_d   = 1'b1;
        rd_addr_d = idx(i_q, j_q);
      end
      StRIj: begin
        a_kj_d  = path_r_p0_rd_data;
        state_d = StCmp;
      end
      StCmp: begin
        state_d   = StWr;
        wr_en_d   = 1'b1;
        wr_addr_d = idx(i_q, j_q);
        wr_data_d = relax_r;
      end
      StWr: begin
        // j innermost, k outermost; the 9-bit carry chain wraps all to 0 at the end.
        {k_d, i_d, j_d} = {k_q, i_q, j_q} + 9'd1;
        if (&{k_q, i_q, j_q}) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d   = StRIk;
          rd_en_d   = 1'b1;
          rd_addr_d = idx(i_d, k_d);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      a_ik_q    <= '0;
      a_kj_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      a_ik_q    <= a_ik_d;
      a_kj_q    <= a_kj_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign path_r_p0_addr_data = rd_addr_q;
  assign path_r_p0_addr_en   = rd_en_q;
  assign path_r_p0_rd_en     = rd_en_q;
  assign path_w_p0_addr_data = wr_addr_q;
  assign path_w_p0_addr_en   = wr_en_q;
  assign path_w_p0_wr_en     = wr_en_q;
  assign path_w_p0_wr_data   = wr_data_q;
  assign done                = done_q;

endmodule

// File: tb/tb_floyd_warshall_kernel.sv
// Self-checking bench: behavioural memory plus a plain triple-loop golden model.
module tb_floyd_warshall_kernel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        t   = 1'b0;
  logic [31:0] n   = 32'd8;
  logic [5:0]  rd_addr, wr_addr;
  logic        rd_aen, rd_en, wr_aen, wr_en, done;
  logic [31:0] rd_data = '0;
  logic [31:0] wr_data;

  logic [31:0] mem [64];
  int signed   ref_m [64];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int proto_viol = 0;

  always #5 clk = ~clk;

  floyd_warshall_kernel dut (
    .clk                 (clk),
    .rst                 (rst),
    .t                   (t),
    .n                   (n),
    .path_r_p0_addr_data (rd_addr),
    .path_r_p0_addr_en   (rd_aen),
    .path_r_p0_rd_en     (rd_en),
    .path_r_p0_rd_data   (rd_data),
    .path_w_p0_addr_data (wr_addr),
    .path_w_p0_addr_en   (wr_aen),
    .path_w_p0_wr_en     (wr_en),
    .path_w_p0_wr_data   (wr_data),
    .done                (done)
  );

  // Registered read, synchronous write.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  always @(negedge clk) begin
    if (rd_en && wr_en) proto_viol = proto_viol + 1;
    if (rd_aen !== rd_en || wr_aen !== wr_en) proto_viol = proto_viol + 1;
    if (!rd_en && rd_addr !== 6'd0) proto_viol = proto_viol + 1;
    if (!wr_en && (wr_addr !== 6'd0 || wr_data !== 32'd0)) proto_viol = proto_viol + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_fw();
    int signed s;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          s = ref_m[i*8+k] + ref_m[k*8+j];
          if (!(ref_m[i*8+j] < s)) ref_m[i*8+j] = s;
        end
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctl"}, {15'd0, rd_addr, rd_aen, rd_en, wr_addr, wr_aen, wr_en, done}, 32'd0);
    check_eq({tag, "_wdata"}, wr_data, 32'd0);
  endtask

  // Start a run, optionally pulse t while busy, and check latency/writes/done/memory.
  task automatic run_and_check(input string name, input bit inject_t);
    int c0, lat, w0, d0;
    bit seen;
    for (int a = 0; a < 64; a++) ref_m[a] = $signed(mem[a]);
    ref_fw();
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk) t = 1'b1;
    @(negedge clk) t = 1'b0;
    c0 = cyc;
    seen = 1'b0;
    lat = 3000;
    for (int it = 0; it < 3000 && !seen; it++) begin
      t = (inject_t && (it == 50 || it == 1200)) ? 1'b1 : 1'b0;
      if (done) begin
        seen = 1'b1;
        lat = cyc - c0;
      end else begin
        @(negedge clk);
      end
    end
    t = 1'b0;
    repeat (20) @(negedge clk);
    check_eq({name, "_latency"}, lat, 32'd2560);
    check_eq({name, "_writes"}, wr_cnt - w0, 32'd512);
    check_eq({name, "_done_pulses"}, done_cnt - d0, 32'd1);
    for (int a = 0; a < 64; a++)
      check_eq($sformatf("%s_word%0d", name, a), mem[a], ref_m[a]);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 32'd0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle");

    // Uniform matrix stays put.
    for (int a = 0; a < 64; a++) mem[a] = 32'd5;
    run_and_check("uniform", 1'b0);

    // Chain graph 0->1->2->3, with t re-pulsed while busy.
    for (int a = 0; a < 64; a++) mem[a] = 32'd100;
    mem[1] = 32'd1; mem[10] = 32'd1; mem[19] = 32'd1;
    run_and_check("chain", 1'b1);
    check_eq("chain_p02", mem[2], 32'd2);
    check_eq("chain_p03", mem[3], 32'd3);
    check_eq("chain_p13", mem[11], 32'd2);
    check_eq("chain_p45", mem[37], 32'd100);

    // Default image.
    for (int a = 0; a < 64; a++) mem[a] = a + 1;
    mem[32] = 32'd0;
    run_and_check("default", 1'b0);
    check_eq("default_w33", mem[33], 32'd2);

    // Wrap and signedness.
    for (int a = 0; a < 64; a++) mem[a] = 32'd0;
    mem[0] = 32'h7FFF_FFFF; mem[1] = 32'd1; mem[8] = 32'h7FFF_FFFF;
    run_and_check("wrap", 1'b0);
    check_eq("wrap_neg", {31'd0, mem[0][31]}, 32'd1);

    // Random matrices, mostly small positive with occasional full-range words.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 64; a++)
        mem[a] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 200);
      run_and_check($sformatf("rand%0d", r), 1'b0);
    end

    // Reset mid-run, then a clean full run from the partial image.
    begin
      int d0;
      for (int a = 0; a < 64; a++) mem[a] = $urandom_range(1, 50);
      d0 = done_cnt;
      @(negedge clk) t = 1'b1;
      @(negedge clk) t = 1'b0;
      repeat (98) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      repeat (3) @(negedge clk);
      check_outputs_zero("midrst_hold");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("midrst_no_done", done_cnt - d0, 32'd0);
      run_and_check("after_rst", 1'b0);
    end

    check_eq("protocol", proto_viol, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floyd_warshall_kernel.md
Name: floyd_warshall_kernel

Overview:
- Hardware Floyd-Warshall all-pairs shortest-path kernel over a fixed 8x8 matrix of 32-bit signed distances held in an external single-port-read / single-port-write memory (64 words, row-major, address = i*8+j).
- Started by a one-cycle pulse on t.
- Performs the in-place relaxation path[i][j] = min(path[i][j], path[i][k]+path[k][j]) for k, i, j in 0..7, loops nested k outermost, j innermost.
- Sits between a memory-wrapper pair (registered read, synchronous write) and a start/clock generator.

Parameters:
- N, 8, matrix dimension (fixed; address width = 6)
- DW, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- t  in  1  start pulse, sampled at rising edge while idle
- n  in  32  problem size; ignored, N is fixed
- path_r_p0_addr_data  out  6  read address
- path_r_p0_addr_en  out  1  read address valid; equals rd_en
- path_r_p0_rd_en  out  1  read request
- path_r_p0_rd_data  in  32  read data, valid exactly 1 cycle after rd_en
- path_w_p0_addr_data  out  6  write address
- path_w_p0_addr_en  out  1  write address valid; equals wr_en
- path_w_p0_wr_en  out  1  write strobe; memory writes at that rising edge
- path_w_p0_wr_data  out  32  write data
- done  out  1  one-cycle pulse when the last write has been issued

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM goes to IDLE; k, i, j counters clear to 0.
  - All outputs are 0: addresses, enables, wr_data, done.
  - The memory is left as-is; a partial result is acceptable.
- FSM states: IDLE, R_IK, R_KJ, R_IJ, CMP, WR.
- IDLE -> R_IK on t=1. t is ignored in all other states.
- R_IK: rd_en=1, addr=i*8+k.
- R_KJ: capture rd_data into a_ik; rd_en=1, addr=k*8+j.
- R_IJ: capture rd_data into a_kj; rd_en=1, addr=i*8+j.
- CMP: capture rd_data into a_ij; compute sum = a_ik + a_kj, 32-bit two's-complement wrap.
  - Result r = (a_ij < sum, signed strict compare) ? a_ij : sum.
- WR: wr_en=1, addr=i*8+j, wr_data=r. The write is always issued, even when r is unchanged.
  - Then advance the loop: j++; on wrap, i++; on wrap, k++.
  - If k, i, j were all 7, pulse done and go to IDLE; otherwise go to R_IK.
- Address and data outputs are registered, driven in the listed state, and return to 0 when their enable is low.
- Each read is issued at least one cycle after any preceding write, so no read-after-write bypass is needed.
- Latency: 5 cycles per (k,i,j) triple, 512 triples.
  - Counting from the edge sampling t, 2560 cycles until done; done is high in the cycle after the final WR.
- Only one read or one write is outstanding at a time. Read and write are never both asserted in the same cycle.

Decomposition:
- Package floyd_warshall_pkg: N=8, AW=6, DW=32, state enum typedef, address helper function idx(row,col)=row*8+col.
- One natural sub-module fw_relax: combinational signed min-plus unit (a_ik, a_kj, a_ij -> r).

Test Plan:
- Reset mid-run: assert rst at cycle 100 -> all outputs 0 immediately, done never pulses; a new t then completes a full run in 2560 cycles.
- Uniform matrix, all 64 words = 5 -> all words remain 5, 512 writes issued, done exactly 2560 cycles after t.
- Chain graph:
  - Setup: all words 100, path[0][1]=1, path[1][2]=1, path[2][3]=1.
  - Required: path[0][2]=2, path[0][3]=3, path[1][3]=2, path[4][5]=100.
- Default image, word[a]=a+1 except word[32]=0:
  - Final memory must match a software golden model using the same signed compare and 32-bit wrap.
  - Example: word[33] (i=4, j=1) = min(34, 0+2) = 2.
- Wrap and signedness:
  - Setup: path[0][0]=0x7FFFFFFF, path[0][1]=1, path[1][0]=0x7FFFFFFF, other words 0.
  - The wrapped negative sum is taken, so path[0][0] becomes negative, matching the golden model bit-exact.
- Protocol check on every cycle:
  - rd_en and wr_en are never both 1; addr_en equals its enable.
  - t pulsed while busy has no effect: total time stays 2560 cycles and there is no second done.
